// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   It shadows the instructions in EX, MEM and WB with a small scoreboard.
//   From that scoreboard it derives the load-use stall, the ALU operand
//   forwarding selects, the ID-stage writeback bypass and the branch flush.
//   It also keeps saturating counters of stall and flush cycles.
//
// Ports
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   id_*_i               decoded fields of the instruction currently in ID
//   branch_taken_i       branch in MEM resolved taken
//   stall_o              hold PC and IF/ID, bubble into ID/EX
//   flush_o              clear IF/ID and ID/EX
//   fwd_rs_o, fwd_rt_o   EX operand source: 00 regfile, 10 EX/MEM, 01 WB
//   id_byp_rs_o/_rt_o    ID operand must take WB write data
//   stall_cnt_o          saturating count of stall cycles
//   flush_cnt_o          saturating count of flush cycles

module pipe_hazard_unit #(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [1:0]        fwd_rs_o,
    output logic [1:0]        fwd_rt_o,
    output logic              id_byp_rs_o,
    output logic              id_byp_rt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } slot_t;

    slot_t             ex_q, mem_q, wb_q;
    // The load flag only matters while the load sits in EX, so only EX keeps it.
    logic              ex_memread_q;
    logic [REG_AW-1:0] ex_rs_q, ex_rt_q;
    logic              ex_use_rs_q, ex_use_rt_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic              hit_ex, hit_mem, hit_wb;
    logic              dep;

    function automatic logic match(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != '0);
    endfunction

    always_comb begin
        hit_ex  = (id_use_rs_i && match(ex_q,  id_rs_i)) || (id_use_rt_i && match(ex_q,  id_rt_i));
        hit_mem = (id_use_rs_i && match(mem_q, id_rs_i)) || (id_use_rt_i && match(mem_q, id_rt_i));
        hit_wb  = (id_use_rs_i && match(wb_q,  id_rs_i)) || (id_use_rt_i && match(wb_q,  id_rt_i));

        flush_o = branch_taken_i && mem_q.valid;

        if (FWD_EN)
            dep = ex_memread_q && hit_ex;
        else
            dep = hit_ex || hit_mem || hit_wb;

        // A taken branch squashes the consumer anyway, so flush wins over stall.
        stall_o = id_valid_i && !flush_o && dep;
    end

    // MEM is checked before WB so the youngest writer supplies the value.
    always_comb begin
        fwd_rs_o = 2'b00;
        fwd_rt_o = 2'b00;
        if (FWD_EN && ex_q.valid) begin
            if (ex_use_rs_q) begin
                if (match(mem_q, ex_rs_q))
                    fwd_rs_o = 2'b10;
                else if (match(wb_q, ex_rs_q))
                    fwd_rs_o = 2'b01;
            end
            if (ex_use_rt_q) begin
                if (match(mem_q, ex_rt_q))
                    fwd_rt_o = 2'b10;
                else if (match(wb_q, ex_rt_q))
                    fwd_rt_o = 2'b01;
            end
        end
    end

    always_comb begin
        id_byp_rs_o = FWD_EN && id_valid_i && id_use_rs_i && match(wb_q, id_rs_i);
        id_byp_rt_o = FWD_EN && id_valid_i && id_use_rt_i && match(wb_q, id_rt_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_memread_q <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_use_rs_q  <= 1'b0;
            ex_use_rt_q  <= 1'b0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= flush_o ? slot_t'('0) : ex_q;
            if (id_valid_i && !stall_o && !flush_o) begin
                ex_q         <= '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i};
                ex_memread_q <= id_memread_i;
                ex_rs_q      <= id_rs_i;
                ex_rt_q      <= id_rt_i;
                ex_use_rs_q  <= id_use_rs_i;
                ex_use_rt_q  <= id_use_rt_i;
            end else begin
                ex_q         <= '0;
                ex_memread_q <= 1'b0;
                ex_rs_q      <= '0;
                ex_rt_q      <= '0;
                ex_use_rs_q  <= 1'b0;
                ex_use_rt_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_o && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit.
// Two instances share the same ID/branch stimulus: one with forwarding and
// 16-bit counters, one without forwarding and 2-bit counters. A reference
// model tracks the in-flight instructions by age and predicts every output.

module tb_pipe_hazard_unit;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, branch_taken;
    logic [AW-1:0] id_rs, id_rt, id_rd;

    logic          stall_a, flush_a, byp_rs_a, byp_rt_a;
    logic [1:0]    fwd_rs_a, fwd_rt_a;
    logic [15:0]   scnt_a, fcnt_a;
    logic          stall_b, flush_b, byp_rs_b, byp_rt_b;
    logic [1:0]    fwd_rs_b, fwd_rt_b;
    logic [1:0]    scnt_b, fcnt_b;

    pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .branch_taken_i(branch_taken),
        .stall_o(stall_a), .flush_o(flush_a), .fwd_rs_o(fwd_rs_a), .fwd_rt_o(fwd_rt_a),
        .id_byp_rs_o(byp_rs_a), .id_byp_rt_o(byp_rt_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a));

    pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b0), .CNT_W(2)) u_nof (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .branch_taken_i(branch_taken),
        .stall_o(stall_b), .flush_o(flush_b), .fwd_rs_o(fwd_rs_b), .fwd_rt_o(fwd_rt_b),
        .id_byp_rs_o(byp_rs_b), .id_byp_rt_o(byp_rt_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b));

    typedef struct {
        bit valid;
        int rd;
        bit rw;
        bit mr;
        int rs;
        bit urs;
        int rt;
        bit urt;
    } ins_t;

    typedef struct {
        int stall;
        int flush;
        int frs;
        int frt;
        int brs;
        int brt;
        int scnt;
        int fcnt;
    } exp_t;

    // pipe[m][0] = EX (youngest), [1] = MEM, [2] = WB (oldest)
    ins_t pipe [2][3];
    int   cnt_s [2];
    int   cnt_f [2];
    bit   fwd_en [2] = '{1'b1, 1'b0};
    int   cmax [2]   = '{65535, 3};
    ins_t bubble;
    ins_t cur;
    bit   cur_br;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    function automatic bit writes(input ins_t s, input int r);
        return s.valid && s.rw && (s.rd == r) && (r != 0);
    endfunction

    // Source of an EX operand: youngest older writer among MEM and WB.
    function automatic int ex_src(input int m, input int r, input bit use_r);
        if (!fwd_en[m] || !pipe[m][0].valid || !use_r) return 0;
        for (int k = 1; k <= 2; k++)
            if (writes(pipe[m][k], r)) return (k == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic exp_t predict(input int m);
        exp_t e;
        bit   hz;
        hz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit dep;
            dep = (cur.urs && writes(pipe[m][k], cur.rs)) || (cur.urt && writes(pipe[m][k], cur.rt));
            if (dep) begin
                if (!fwd_en[m]) hz = 1'b1;
                else if (k == 0 && pipe[m][0].mr) hz = 1'b1;
            end
        end
        e.flush = (cur_br && pipe[m][1].valid) ? 1 : 0;
        e.stall = (cur.valid && !e.flush && hz) ? 1 : 0;
        e.frs   = ex_src(m, pipe[m][0].rs, pipe[m][0].urs);
        e.frt   = ex_src(m, pipe[m][0].rt, pipe[m][0].urt);
        e.brs   = (fwd_en[m] && cur.valid && cur.urs && writes(pipe[m][2], cur.rs)) ? 1 : 0;
        e.brt   = (fwd_en[m] && cur.valid && cur.urt && writes(pipe[m][2], cur.rt)) ? 1 : 0;
        e.scnt  = cnt_s[m];
        e.fcnt  = cnt_f[m];
        return e;
    endfunction

    task automatic advance(input int m);
        exp_t e;
        e = predict(m);
        if (e.stall != 0 && cnt_s[m] < cmax[m]) cnt_s[m]++;
        if (e.flush != 0 && cnt_f[m] < cmax[m]) cnt_f[m]++;
        pipe[m][2] = pipe[m][1];
        pipe[m][1] = (e.flush != 0) ? bubble : pipe[m][0];
        pipe[m][0] = (cur.valid && e.stall == 0 && e.flush == 0) ? cur : bubble;
    endtask

    task automatic clear_model();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) pipe[m][k] = bubble;
            cnt_s[m] = 0;
            cnt_f[m] = 0;
        end
    endtask

    task automatic drive();
        id_valid     = cur.valid;
        id_rd        = AW'(cur.rd);
        id_regwrite  = cur.rw;
        id_memread   = cur.mr;
        id_rs        = AW'(cur.rs);
        id_use_rs    = cur.urs;
        id_rt        = AW'(cur.rt);
        id_use_rt    = cur.urt;
        branch_taken = cur_br;
    endtask

    // One cycle: let the model follow the edge just taken, then present the
    // next ID contents and queue the outputs they should produce.
    task automatic step(input ins_t s, input bit br, input bit rst_next);
        @(posedge clk);
        #1;
        if (!rst) begin
            advance(0);
            advance(1);
        end
        rst = rst_next;
        if (rst_next) clear_model();
        cur    = s;
        cur_br = br;
        drive();
        q0.push_back(predict(0));
        q1.push_back(predict(1));
    endtask

    function automatic ins_t mk(input bit v, input int rd, input bit rw, input bit mr,
                                input int rs, input bit urs, input int rt, input bit urt);
        ins_t i;
        i.valid = v; i.rd = rd; i.rw = rw; i.mr = mr;
        i.rs = rs; i.urs = urs; i.rt = rt; i.urt = urt;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.valid = ($urandom_range(0, 9) != 0);
        i.rd    = $urandom_range(0, 7);
        i.rw    = ($urandom_range(0, 9) < 7);
        i.mr    = i.rw && ($urandom_range(0, 9) < 3);
        i.rs    = $urandom_range(0, 7);
        i.urs   = ($urandom_range(0, 3) != 0);
        i.rt    = $urandom_range(0, 7);
        i.urt   = ($urandom_range(0, 3) != 0);
        return i;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("fwd.stall",  32'(stall_a),  32'(e.stall));
                chk("fwd.flush",  32'(flush_a),  32'(e.flush));
                chk("fwd.fwd_rs", 32'(fwd_rs_a), 32'(e.frs));
                chk("fwd.fwd_rt", 32'(fwd_rt_a), 32'(e.frt));
                chk("fwd.byp_rs", 32'(byp_rs_a), 32'(e.brs));
                chk("fwd.byp_rt", 32'(byp_rt_a), 32'(e.brt));
                chk("fwd.scnt",   32'(scnt_a),   32'(e.scnt));
                chk("fwd.fcnt",   32'(fcnt_a),   32'(e.fcnt));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("nof.stall",  32'(stall_b),  32'(e.stall));
                chk("nof.flush",  32'(flush_b),  32'(e.flush));
                chk("nof.fwd_rs", 32'(fwd_rs_b), 32'(e.frs));
                chk("nof.fwd_rt", 32'(fwd_rt_b), 32'(e.frt));
                chk("nof.byp_rs", 32'(byp_rs_b), 32'(e.brs));
                chk("nof.byp_rt", 32'(byp_rt_b), 32'(e.brt));
                chk("nof.scnt",   32'(scnt_b),   32'(e.scnt));
                chk("nof.fcnt",   32'(fcnt_b),   32'(e.fcnt));
            end
        end
    end

    initial begin : stimulus
        clear_model();
        cur    = bubble;
        cur_br = 1'b0;
        drive();

        // reset state
        step(bubble, 1'b0, 1'b1);
        step(bubble, 1'b0, 1'b0);

        // load-use: lw $2,0($1) ; add $5,$2,$3 held in ID
        step(mk(1, 2, 1, 1, 1, 1, 0, 0), 1'b0, 1'b0);
        repeat (3) step(mk(1, 5, 1, 0, 2, 1, 3, 1), 1'b0, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // EX/MEM forward: add $3,$1,$1 ; sub $4,$3,$5
        step(mk(1, 3, 1, 0, 1, 1, 1, 1), 1'b0, 1'b0);
        step(mk(1, 4, 1, 0, 3, 1, 5, 1), 1'b0, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // two writers of $6, then a reader of $6
        step(mk(1, 6, 1, 0, 1, 1, 1, 1), 1'b0, 1'b0);
        step(mk(1, 6, 1, 0, 2, 1, 2, 1), 1'b0, 1'b0);
        step(mk(1, 8, 1, 0, 6, 1, 0, 0), 1'b0, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // WB writes $7 while ID reads $7 as rt
        step(mk(1, 7, 1, 0, 1, 1, 1, 1), 1'b0, 1'b0);
        repeat (2) step(bubble, 1'b0, 1'b0);
        step(mk(1, 9, 1, 0, 1, 0, 7, 1), 1'b0, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // register 0 is never a hazard
        step(mk(1, 0, 1, 1, 1, 1, 0, 0), 1'b0, 1'b0);
        repeat (2) step(mk(1, 5, 1, 0, 0, 1, 0, 1), 1'b0, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // taken branch in MEM while a load-use is pending
        step(mk(1, 10, 1, 0, 1, 1, 1, 1), 1'b0, 1'b0);
        step(mk(1, 2, 1, 1, 1, 1, 0, 0), 1'b0, 1'b0);
        step(mk(1, 5, 1, 0, 2, 1, 0, 0), 1'b1, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // back-to-back dependent adds, reset asserted mid-sequence
        step(mk(1, 1, 1, 0, 3, 1, 4, 1), 1'b0, 1'b0);
        repeat (4) step(mk(1, 2, 1, 0, 1, 1, 1, 1), 1'b0, 1'b0);
        step(mk(1, 3, 1, 0, 2, 1, 2, 1), 1'b0, 1'b0);
        step(mk(1, 3, 1, 0, 2, 1, 2, 1), 1'b0, 1'b1);
        step(mk(1, 3, 1, 0, 2, 1, 2, 1), 1'b0, 1'b1);
        step(mk(1, 4, 1, 0, 3, 1, 3, 1), 1'b0, 1'b0);
        repeat (3) step(bubble, 1'b0, 1'b0);

        // random traffic on a small register set, with a reset in the middle
        for (int i = 0; i < 400; i++)
            step(rnd_ins(), ($urandom_range(0, 9) == 0), (i >= 200 && i < 202));

        step(bubble, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
